// File: rtl/dm_ctrl.sv
// Multi-cycle MEM-stage data-memory controller for the Ram1 SRAM and the
// memory-mapped UART that shares its data bus.
module dm_ctrl #(
  parameter int                DATA_W         = 16,
  parameter int                ADDR_W         = 16,
  parameter int                RAM_ADDR_W     = 18,
  parameter int                WAIT_CYCLES    = 1,
  parameter logic [ADDR_W-1:0] UART_DATA_ADDR = 'hBF00,
  parameter logic [ADDR_W-1:0] UART_STAT_ADDR = 'hBF01,
  parameter int                TX_TIMEOUT     = 1023
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  input  logic [ADDR_W-1:0]     Addr,
  input  logic [DATA_W-1:0]     WData,
  output logic [DATA_W-1:0]     RData,
  output logic                  Busy,
  output logic                  Ack,
  output logic                  Err,
  output logic                  Ram_EN,
  output logic                  Ram_OE,
  output logic                  Ram_WE,
  output logic [RAM_ADDR_W-1:0] Ram_address,
  inout  wire  [DATA_W-1:0]     Ram_data,
  input  logic                  data_ready,
  input  logic                  tbre,
  input  logic                  tsre,
  output logic                  rdn,
  output logic                  wrn
);

  localparam int WW = $clog2(WAIT_CYCLES + 1);
  localparam int TW = $clog2(TX_TIMEOUT + 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(WAIT_CYCLES);
  localparam logic [TW-1:0] TO_LAST   = TW'(TX_TIMEOUT - 1);

  typedef enum logic [3:0] {
    IDLE, RD, WSET, WPULSE, URD, UWSET, UWPULSE, UWTBRE, UWTSRE, DONE
  } state_t;

  state_t                r_state;
  logic [WW-1:0]         r_wait;
  logic [TW-1:0]         r_to;
  logic [DATA_W-1:0]     r_wdata;
  logic [DATA_W-1:0]     r_rdata;
  logic [RAM_ADDR_W-1:0] r_addr;
  logic                  r_drive;
  logic                  r_en, r_oe, r_we, r_rdn, r_wrn, r_err;
  logic                  w_waitDone;
  logic                  w_toDone;

  assign w_waitDone  = (r_wait == WAIT_LAST);
  assign w_toDone    = (r_to >= TO_LAST);

  assign Ram_data    = r_drive ? r_wdata : {DATA_W{1'bz}};
  assign Ram_address = r_addr;
  assign Ram_EN      = r_en;
  assign Ram_OE      = r_oe;
  assign Ram_WE      = r_we;
  assign rdn         = r_rdn;
  assign wrn         = r_wrn;
  assign RData       = r_rdata;
  assign Err         = r_err;
  assign Ack         = (r_state == DONE);
  assign Busy        = (MemRead | MemWrite) & (r_state != DONE) & ~Rst;

  // Strobes are registered alongside the state so each one changes on the
  // same edge that enters the state it belongs to.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_state <= IDLE;
      r_wait  <= '0;
      r_to    <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_addr  <= '0;
      r_drive <= 1'b0;
      r_en    <= 1'b1;
      r_oe    <= 1'b1;
      r_we    <= 1'b1;
      r_rdn   <= 1'b1;
      r_wrn   <= 1'b1;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (MemWrite) begin
            r_addr <= RAM_ADDR_W'(Addr);
            if (Addr == UART_DATA_ADDR) begin
              r_wdata <= DATA_W'(WData[7:0]);
              r_drive <= 1'b1;
              r_state <= UWSET;
            end else if (Addr == UART_STAT_ADDR) begin
              // The status register is read-only; a store just completes.
              r_state <= DONE;
            end else begin
              r_wdata <= WData;
              r_drive <= 1'b1;
              r_en    <= 1'b0;
              r_state <= WSET;
            end
          end else if (MemRead) begin
            r_addr <= RAM_ADDR_W'(Addr);
            r_wait <= WW'(1);
            if (Addr == UART_STAT_ADDR) begin
              r_rdata <= DATA_W'({data_ready, tbre & tsre});
              r_state <= DONE;
            end else if (Addr == UART_DATA_ADDR) begin
              r_rdn   <= 1'b0;
              r_state <= URD;
            end else begin
              r_en    <= 1'b0;
              r_oe    <= 1'b0;
              r_state <= RD;
            end
          end
        end
        RD: begin
          if (w_waitDone) begin
            r_rdata <= Ram_data;
            r_en    <= 1'b1;
            r_oe    <= 1'b1;
            r_state <= DONE;
          end else begin
            r_wait <= r_wait + WW'(1);
          end
        end
        WSET: begin
          r_we    <= 1'b0;
          r_wait  <= WW'(1);
          r_state <= WPULSE;
        end
        WPULSE: begin
          // Chip enable and data stay asserted into DONE for write hold time.
          if (w_waitDone) begin
            r_we    <= 1'b1;
            r_state <= DONE;
          end else begin
            r_wait <= r_wait + WW'(1);
          end
        end
        URD: begin
          if (w_waitDone) begin
            r_rdata <= DATA_W'(Ram_data[7:0]);
            r_rdn   <= 1'b1;
            r_state <= DONE;
          end else begin
            r_wait <= r_wait + WW'(1);
          end
        end
        UWSET: begin
          r_wrn   <= 1'b0;
          r_wait  <= WW'(1);
          r_state <= UWPULSE;
        end
        UWPULSE: begin
          if (w_waitDone) begin
            r_wrn   <= 1'b1;
            r_drive <= 1'b0;
            r_to    <= '0;
            r_state <= UWTBRE;
          end else begin
            r_wait <= r_wait + WW'(1);
          end
        end
        UWTBRE: begin
          if (tbre) begin
            r_to    <= r_to + TW'(1);
            r_state <= UWTSRE;
          end else if (w_toDone) begin
            r_err   <= 1'b1;
            r_state <= DONE;
          end else begin
            r_to <= r_to + TW'(1);
          end
        end
        UWTSRE: begin
          if (tsre) begin
            r_state <= DONE;
          end else if (w_toDone) begin
            r_err   <= 1'b1;
            r_state <= DONE;
          end else begin
            r_to <= r_to + TW'(1);
          end
        end
        DONE: begin
          r_drive <= 1'b0;
          r_en    <= 1'b1;
          r_oe    <= 1'b1;
          r_we    <= 1'b1;
          r_rdn   <= 1'b1;
          r_wrn   <= 1'b1;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dm_ctrl.sv
// Directed bench for dm_ctrl: instance A (1 wait state, short TX timeout)
// and instance B (3 wait states), each with a small behavioural SRAM.
module tb_dm_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  memRead = '0, memWrite = '0;
  logic [15:0] addrA = '0, addrB = '0, wDataA = '0, wDataB = '0;
  logic        dataReady = 1'b0, tbre = 1'b1, tsre = 1'b1;
  logic [7:0]  rxByte = 8'h00;
  logic        probeA = 1'b0;

  wire  [1:0]  busy, ack, err, ramEn, ramOe, ramWe, rdn, wrn;
  wire  [15:0] rDataA, rDataB;
  wire  [17:0] ramAddrA, ramAddrB;
  wire  [15:0] ramDataA, ramDataB;

  logic [15:0] memA [256];
  logic [15:0] memB [256];
  logic        drvA, drvB;
  logic [15:0] valA, valB;

  int vectors = 0, miscompares = 0;
  int busyCnt, weLow, oeLow, enLow, rdnLow, wrnLow, wrnIdx, ackIdx;
  int tbreDelay, tsreDelay;
  logic [15:0] weBus;
  logic [17:0] weAddr;
  logic [7:0]  wrnBus;
  logic [15:0] sb [$];

  always #5 clk = ~clk;

  dm_ctrl #(.WAIT_CYCLES(1), .TX_TIMEOUT(8)) dutA (
    .Clk(clk), .Rst(rst), .MemRead(memRead[0]), .MemWrite(memWrite[0]),
    .Addr(addrA), .WData(wDataA), .RData(rDataA), .Busy(busy[0]),
    .Ack(ack[0]), .Err(err[0]), .Ram_EN(ramEn[0]), .Ram_OE(ramOe[0]),
    .Ram_WE(ramWe[0]), .Ram_address(ramAddrA), .Ram_data(ramDataA),
    .data_ready(dataReady), .tbre(tbre), .tsre(tsre), .rdn(rdn[0]), .wrn(wrn[0])
  );

  dm_ctrl #(.WAIT_CYCLES(3)) dutB (
    .Clk(clk), .Rst(rst), .MemRead(memRead[1]), .MemWrite(memWrite[1]),
    .Addr(addrB), .WData(wDataB), .RData(rDataB), .Busy(busy[1]),
    .Ack(ack[1]), .Err(err[1]), .Ram_EN(ramEn[1]), .Ram_OE(ramOe[1]),
    .Ram_WE(ramWe[1]), .Ram_address(ramAddrB), .Ram_data(ramDataB),
    .data_ready(dataReady), .tbre(tbre), .tsre(tsre), .rdn(rdn[1]), .wrn(wrn[1])
  );

  // Bus side of the SRAM/UART models; probeA forces a known value to show the DUT is off the bus.
  assign drvA = probeA | (~ramEn[0] & ~ramOe[0] & ramWe[0]) | ~rdn[0];
  assign valA = probeA ? 16'h5A5A : (~rdn[0] ? {8'hA5, rxByte} : memA[ramAddrA[7:0]]);
  assign ramDataA = drvA ? valA : 16'hzzzz;
  assign drvB = (~ramEn[1] & ~ramOe[1] & ramWe[1]) | ~rdn[1];
  assign valB = ~rdn[1] ? {8'hA5, rxByte} : memB[ramAddrB[7:0]];
  assign ramDataB = drvB ? valB : 16'hzzzz;

  always @(posedge clk) begin
    if (!ramEn[0] && !ramWe[0]) memA[ramAddrA[7:0]] <= ramDataA;
    if (!ramEn[1] && !ramWe[1]) memB[ramAddrB[7:0]] <= ramDataB;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic setReq(input int d, input logic rd, input logic wr,
                        input logic [15:0] a, input logic [15:0] wd);
    memRead[d]  = rd;
    memWrite[d] = wr;
    if (d == 0) begin addrA = a; wDataA = wd; end
    else        begin addrB = a; wDataB = wd; end
  endtask

  // One CPU access, held until Ack; gathers strobe statistics and scores the load data.
  task automatic applyStimulus(input int d, input logic rd, input logic wr,
                               input logic [15:0] a, input logic [15:0] wd,
                               input logic [15:0] expR, input bit txModel);
    bit done = 0;
    logic [15:0] bus, rdv, expv;
    busyCnt = 0; weLow = 0; oeLow = 0; enLow = 0; rdnLow = 0; wrnLow = 0;
    wrnIdx = -1; ackIdx = -1; weBus = '0; weAddr = '0; wrnBus = '0;
    @(negedge clk);
    setReq(d, rd, wr, a, wd);
    if (rd && !wr) sb.push_back(expR);
    if (txModel) begin tbre = 1'b0; tsre = 1'b0; end
    for (int i = 0; i < 60 && !done; i++) begin
      if (i == 0) #1; else @(negedge clk);
      bus = (d == 0) ? ramDataA : ramDataB;
      rdv = (d == 0) ? rDataA : rDataB;
      if (!ramWe[d]) begin weLow++; weBus = bus; weAddr = (d == 0) ? ramAddrA : ramAddrB; end
      if (!ramOe[d]) oeLow++;
      if (!ramEn[d]) enLow++;
      if (!rdn[d]) rdnLow++;
      if (!wrn[d]) begin
        if (wrnIdx < 0) wrnIdx = i;
        wrnLow++;
        wrnBus = bus[7:0];
      end
      if (busy[d]) busyCnt++;
      if (ack[d]) begin
        ackIdx = i;
        done = 1;
        if (rd && !wr) begin
          expv = (sb.size() > 0) ? sb.pop_front() : 16'hDEAD;
          checkOutput("rdata", 32'(rdv), 32'(expv));
        end
        setReq(d, 1'b0, 1'b0, a, wd);
      end
      if (txModel && wrnIdx >= 0) begin
        tbre = (i - wrnIdx >= tbreDelay);
        tsre = (tsreDelay >= 0) && (i - wrnIdx >= tsreDelay);
      end
    end
    if (!done) begin
      checkOutput("ack_wait", 32'(0), 32'(1));
      setReq(d, 1'b0, 1'b0, a, wd);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    memRead[0] = 1'b1;
    #12;
    checkOutput("rst_busy", 32'(busy[0]), 32'(0));
    checkOutput("rst_strobes", 32'({ramEn[0], ramOe[0], ramWe[0], rdn[0], wrn[0]}), 32'h1F);
    checkOutput("rst_addr", 32'(ramAddrA), 32'(0));
    checkOutput("rst_rdata", 32'(rDataA), 32'(0));
    checkOutput("rst_ack_err", 32'({ack[0], err[0]}), 32'(0));
    @(negedge clk);
    memRead[0] = 1'b0;
    rst = 1'b0;

    // SRAM store then load, one wait state
    applyStimulus(0, 1'b0, 1'b1, 16'h0040, 16'hBEEF, 16'h0000, 0);
    checkOutput("st_busy", 32'(busyCnt), 32'(3));
    checkOutput("st_we_low", 32'(weLow), 32'(1));
    checkOutput("st_we_bus", 32'(weBus), 32'hBEEF);
    checkOutput("st_we_addr", 32'(weAddr), 32'h00040);
    checkOutput("st_ack", 32'(ackIdx), 32'(3));
    applyStimulus(0, 1'b1, 1'b0, 16'h0040, 16'h0000, 16'hBEEF, 0);
    checkOutput("ld_busy", 32'(busyCnt), 32'(2));
    checkOutput("ld_oe_low", 32'(oeLow), 32'(1));

    // UART status read: bit1 data_ready, bit0 tbre&tsre
    dataReady = 1'b1; tbre = 1'b1; tsre = 1'b0;
    applyStimulus(0, 1'b1, 1'b0, 16'hBF01, 16'h0000, 16'h0002, 0);
    checkOutput("stat_busy", 32'(busyCnt), 32'(1));
    checkOutput("stat_quiet", 32'(enLow + rdnLow + wrnLow), 32'(0));

    // UART data read takes only the low byte
    rxByte = 8'h7E;
    applyStimulus(0, 1'b1, 1'b0, 16'hBF00, 16'h0000, 16'h007E, 0);
    checkOutput("urd_rdn_low", 32'(rdnLow), 32'(1));
    checkOutput("urd_en", 32'(enLow), 32'(0));

    // UART store: tbre 3, tsre 5 cycles after the wrn pulse
    tbreDelay = 3; tsreDelay = 5;
    applyStimulus(0, 1'b0, 1'b1, 16'hBF00, 16'h1241, 16'h0000, 1);
    checkOutput("uwr_wrn_idx", 32'(wrnIdx), 32'(2));
    checkOutput("uwr_wrn_low", 32'(wrnLow), 32'(1));
    checkOutput("uwr_bus", 32'(wrnBus), 32'h41);
    checkOutput("uwr_en", 32'(enLow), 32'(0));
    checkOutput("uwr_ack", 32'(ackIdx), 32'(2 + 5 + 1));
    checkOutput("uwr_err", 32'(err[0]), 32'(0));

    // TX timeout: tsre never rises, 8 wait cycles then Ack with Err
    tbreDelay = 3; tsreDelay = -1;
    applyStimulus(0, 1'b0, 1'b1, 16'hBF00, 16'h0055, 16'h0000, 1);
    checkOutput("to_ack", 32'(ackIdx), 32'(2 + 1 + 8));
    checkOutput("to_bus", 32'(wrnBus), 32'h55);
    checkOutput("to_err", 32'(err[0]), 32'(1));
    dataReady = 1'b0; tbre = 1'b1; tsre = 1'b1;
    applyStimulus(0, 1'b1, 1'b0, 16'hBF01, 16'h0000, 16'h0001, 0);
    checkOutput("to_err_sticky", 32'(err[0]), 32'(1));

    // Reset in the middle of the SRAM write pulse
    @(negedge clk);
    setReq(0, 1'b0, 1'b1, 16'h0041, 16'h1111);
    @(negedge clk);
    @(negedge clk);
    checkOutput("mid_we_pulse", 32'(ramWe[0]), 32'(0));
    rst = 1'b1;
    probeA = 1'b1;
    #1;
    checkOutput("mid_rst_we_en", 32'({ramWe[0], ramEn[0]}), 32'h3);
    checkOutput("mid_rst_busy", 32'(busy[0]), 32'(0));
    checkOutput("mid_rst_bus_z", 32'(ramDataA), 32'h5A5A);
    probeA = 1'b0;
    setReq(0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    @(negedge clk);
    rst = 1'b0;
    checkOutput("rst_err_clear", 32'(err[0]), 32'(0));
    applyStimulus(0, 1'b1, 1'b0, 16'h0040, 16'h0000, 16'hBEEF, 0);
    checkOutput("post_rst_busy", 32'(busyCnt), 32'(2));

    // Three wait states; read+write together performs the write
    applyStimulus(1, 1'b1, 1'b1, 16'h0123, 16'hCAFE, 16'h0000, 0);
    checkOutput("w3_we_low", 32'(weLow), 32'(3));
    checkOutput("w3_oe_low", 32'(oeLow), 32'(0));
    checkOutput("w3_st_busy", 32'(busyCnt), 32'(5));
    checkOutput("w3_we_bus", 32'(weBus), 32'hCAFE);
    checkOutput("w3_we_addr", 32'(weAddr), 32'h00123);
    applyStimulus(1, 1'b1, 1'b0, 16'h0123, 16'h0000, 16'hCAFE, 0);
    checkOutput("w3_ld_oe_low", 32'(oeLow), 32'(3));
    checkOutput("w3_ld_busy", 32'(busyCnt), 32'(4));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
